// File: rtl/p2s_pkg.sv
// p2s_pkg: shared state type, counter sizing and width helpers for fifo_p2s_serializer
package p2s_pkg;

    localparam int P2S_MAX_W = 11;
    localparam int CNT_W     = $clog2(P2S_MAX_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } p2s_state_t;

    // Out-of-range widths (0 or above the maximum) fall back to the full word.
    function automatic logic [CNT_W-1:0] eff_width(input logic [3:0] sig, input int max_w);
        return (sig != 4'd0 && int'(sig) <= max_w) ? CNT_W'(sig) : CNT_W'(max_w);
    endfunction

    // Keeps only the low w bits of a word.
    function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [CNT_W-1:0] w);
        return d & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/p2s_shreg.sv
// p2s_shreg: masked word shift register with bit counter, last-bit detect and optional parity (P2S_PARITY_EN)
module p2s_shreg
    import p2s_pkg::*;
#(
    parameter int W = P2S_MAX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [W-1:0]     i_data,
    input  logic [CNT_W-1:0] i_width,
    output logic             o_bit,
    output logic             o_last
);

    logic [W-1:0]     r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic [W-1:0]     w_masked;

    assign w_masked = W'(mask_word(32'(i_data), i_width));

    // Load a masked word and latch its length, or drop one bit per accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else if (i_load) begin
            r_sh  <= w_masked;
            r_cnt <= '0;
            r_len <= i_width;
        end else if (i_shift) begin
            r_sh  <= r_sh >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef P2S_PARITY_EN
    logic r_par;

    // Even parity of the masked word, sent as one extra bit after the data
    always_ff @(posedge clk) begin
        if (rst)
            r_par <= 1'b0;
        else if (i_load)
            r_par <= ^w_masked;
    end

    assign o_last = (r_cnt == r_len);
    assign o_bit  = o_last ? r_par : r_sh[0];
`else
    assign o_last = (r_cnt == r_len - CNT_W'(1));
    assign o_bit  = r_sh[0];
`endif

endmodule

// File: rtl/fifo_p2s_serializer.sv
// fifo_p2s_serializer: pops FIFO words and shifts them out LSB-first on a 1-bit valid/ready stream; P2S_PARITY_EN appends even parity
module fifo_p2s_serializer
    import p2s_pkg::*;
#(
    parameter int max_FIFO_WIDTH = P2S_MAX_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      empty,
    output logic                      pop,
    input  logic [max_FIFO_WIDTH-1:0] pop_data,
    input  logic [3:0]                sig_FIFO_WIDTH,
    output logic                      ser_valid,
    output logic                      ser_data,
    output logic                      ser_last,
    input  logic                      ser_ready,
    output logic                      busy
);

    p2s_state_t       r_state;
    p2s_state_t       w_next;
    logic             w_hs;
    logic             w_done;
    logic             w_bit;
    logic             w_last;
    logic [CNT_W-1:0] w_eff_w;

    assign w_eff_w = eff_width(sig_FIFO_WIDTH, max_FIFO_WIDTH);

    // Handshake, pop request and next state; a finished word chains straight into the next fetch
    always_comb begin
        w_hs   = (r_state == SHIFT) && ser_ready;
        w_done = w_hs && w_last;
        pop    = !empty && ((r_state == IDLE) || w_done);
        w_next = (r_state == FETCH) ? SHIFT :
                 (r_state == SHIFT && !w_done) ? SHIFT :
                 empty ? IDLE : FETCH;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    p2s_shreg #(.W(max_FIFO_WIDTH)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (r_state == FETCH),
        .i_shift (w_hs),
        .i_data  (pop_data),
        .i_width (w_eff_w),
        .o_bit   (w_bit),
        .o_last  (w_last)
    );

    assign ser_valid = (r_state == SHIFT);
    assign ser_data  = ser_valid && w_bit;
    assign ser_last  = ser_valid && w_last;
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/fifo_p2s_serializer.md
Name: fifo_p2s_serializer

Overview:
- Downstream stage of the signal-configurable FIFO (fifo_with_sig).
- Pops one word at a time when the FIFO is not empty and shifts it out LSB-first as a 1-bit valid/ready stream.
- Word length is set at runtime by sig_FIFO_WIDTH, the same signal that drives the FIFO.

Parameters:
max_FIFO_WIDTH, 11, maximum word width; sets the pop_data port width and the shift register size.

Ports:
clk  input  1  clock; one clock; reset is synchronous and active-high
rst  input  1  synchronous active-high reset
empty  input  1  FIFO empty flag
pop  output  1  FIFO pop request; one-cycle pulse
pop_data  input  max_FIFO_WIDTH  FIFO read data; valid the cycle after pop
sig_FIFO_WIDTH  input  4  runtime word width; legal 8..11; stable after reset
ser_valid  output  1  serial bit valid
ser_data  output  1  serial bit
ser_ready  input  1  downstream accepts bit
ser_last  output  1  marks the final bit of the current word
busy  output  1  a word is being fetched or shifted

Behaviour:
- Reset: state=IDLE; pop=0, ser_valid=0, ser_data=0, ser_last=0, busy=0; shift register and bit counter cleared. Reset is sampled on the clk edge only.
- Width rule: eff_w = sig_FIFO_WIDTH if it lies in 1..max_FIFO_WIDTH, else max_FIFO_WIDTH. eff_w is latched into the word length at the FETCH capture.
- States: IDLE, FETCH, SHIFT.
- IDLE:
  - pop = !empty (combinational).
  - If !empty, go to FETCH.
- FETCH (single cycle):
  - Capture pop_data & ((1<<eff_w)-1) into the shift register.
  - Set bit count to 0; go to SHIFT.
- SHIFT:
  - ser_valid=1; ser_data = shreg[0].
  - ser_last=1 when bit count == eff_w-1.
  - On ser_valid&&ser_ready: shift right by 1 and increment the count.
  - On the last-bit handshake: if !empty, assert pop in the same cycle and go to FETCH; else go to IDLE.
- busy = (state != IDLE).
- Latency: pop to first ser_valid is 2 cycles. Back-to-back words have exactly a 1-cycle ser_valid gap (the FETCH cycle).
- Backpressure:
  - ser_data and ser_last are held stable while ser_valid && !ser_ready.
  - ser_valid never drops mid-word.
- Pop rules:
  - pop is never asserted when empty=1.
  - pop is never asserted while a word is being shifted, except on its last-bit handshake.
  - At most one pop per word.
- Reset mid-word: the partially sent word is discarded; there is no re-pop and no further bits of it are emitted.
- sig_FIFO_WIDTH changes after reset are unsupported. The latched length protects any in-flight word.

Optional Feature:
- Macro P2S_PARITY_EN.
- When defined:
  - One even-parity bit (^ of the masked word) is appended after the data bits.
  - ser_last moves to the parity bit.
  - A word occupies eff_w+1 handshakes.
- When undefined: no parity bit; ser_last is on data bit eff_w-1.

Decomposition:
- Package p2s_pkg holds:
  - state enum typedef (IDLE, FETCH, SHIFT);
  - localparam CNT_W = $clog2(max_FIFO_WIDTH+1);
  - function for eff_w clamping and mask generation.
- Sub-module p2s_shreg: shift register, bit counter, last detect and parity; load/shift inputs. The FSM stays in the top level.

Test Plan:
- Width 8, FIFO holds 0xA5, ser_ready=1 -> pop pulses once; 2 cycles later bits 1,0,1,0,0,1,0,1; ser_last on the 8th bit; then IDLE, busy=0.
- Width 11, word 0x5A3 -> 11 bits 1,1,0,0,0,1,0,1,1,0,1; ser_last on bit 11; sent bits reassemble to 0x5A3.
- Width 9, word 0x7FF -> only 9 ones emitted (masked); count and ser_last at the 9th bit.
- Two words 0x01, 0x80 queued, width 8 -> second pop coincides with the last-bit handshake of word 1; exactly one idle ser_valid cycle between the words.
- ser_ready toggling 1,0,0,1 during word 0x3C -> ser_data/ser_last stable while stalled; output sequence unchanged; one pop only.
- empty=1 for 20 cycles -> pop=0, ser_valid=0 throughout.
- rst=1 at bit 4 of 0xFF -> next cycle all outputs 0; with FIFO empty, no further bits are emitted.
- With P2S_PARITY_EN, width 8, 0xA5 -> 9th bit = 0, ser_last on the 9th; 0xA4 -> 9th bit = 1.
